// File: rtl/hazard_fwd_unit_if.sv
// Issue-slot / forwarding-select bundle between decode and the hazard/forwarding unit.
// With HAZ_PERF_CNT_EN defined the bundle also carries the perf-counter clear and counts.
interface hazard_fwd_unit_if #(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 3
);
    logic              hold;
    logic              flush;
    logic              issue_valid;
    logic [REG_AW-1:0] issue_rs;
    logic [REG_AW-1:0] issue_rt;
    logic              issue_use_rs;
    logic              issue_use_rt;
    logic              issue_wr_en;
    logic [REG_AW-1:0] issue_wr_addr;
    logic              issue_is_load;
    logic [SEL_W-1:0]  fwd_sel_a;
    logic [SEL_W-1:0]  fwd_sel_b;
    logic              stall;
    logic              table_busy;
`ifdef HAZ_PERF_CNT_EN
    logic              cnt_clr;
    logic [31:0]       stall_cnt;
    logic [31:0]       fwd_cnt;
`endif

    modport master (
        output hold, flush, issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
               issue_wr_en, issue_wr_addr, issue_is_load,
`ifdef HAZ_PERF_CNT_EN
        output cnt_clr,
        input  stall_cnt, fwd_cnt,
`endif
        input  fwd_sel_a, fwd_sel_b, stall, table_busy
    );

    modport slave (
        input  hold, flush, issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
               issue_wr_en, issue_wr_addr, issue_is_load,
`ifdef HAZ_PERF_CNT_EN
        input  cnt_clr,
        output stall_cnt, fwd_cnt,
`endif
        output fwd_sel_a, fwd_sel_b, stall, table_busy
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// DEPTH-entry writeback-producer table driving operand forward selects and load-use stall.
// Optional HAZ_PERF_CNT_EN adds saturating stall/forward event counters.
module hazard_fwd_unit #(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 2,
    parameter int LOAD_AVAIL = 1,
    parameter int SEL_W      = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    hazard_fwd_unit_if.slave     bus
);
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [DEPTH-1:0]  ld_q, ld_d;
    logic [REG_AW-1:0] addr_q [DEPTH];
    logic [REG_AW-1:0] addr_d [DEPTH];

    logic [SEL_W-1:0]  sel_a, sel_b;
    logic              hit_a, hit_b, ldu_a, ldu_b;
    logic              stall_int;

    // Youngest matching stage wins; an older entry can never mask a younger load
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        hit_a = 1'b0;
        hit_b = 1'b0;
        ldu_a = 1'b0;
        ldu_b = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!hit_a && vld_q[k] && addr_q[k] == bus.issue_rs && addr_q[k] != '0 &&
                bus.issue_use_rs && bus.issue_valid) begin
                hit_a = 1'b1;
                sel_a = SEL_W'(k + 1);
                ldu_a = ld_q[k] && (k < LOAD_AVAIL);
            end
            if (!hit_b && vld_q[k] && addr_q[k] == bus.issue_rt && addr_q[k] != '0 &&
                bus.issue_use_rt && bus.issue_valid) begin
                hit_b = 1'b1;
                sel_b = SEL_W'(k + 1);
                ldu_b = ld_q[k] && (k < LOAD_AVAIL);
            end
        end
        stall_int = (ldu_a || ldu_b) && !bus.flush;
    end

    always_comb begin
        vld_d  = vld_q;
        ld_d   = ld_q;
        addr_d = addr_q;
        if (!bus.hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[k]  = vld_q[k-1];
                ld_d[k]   = ld_q[k-1];
                addr_d[k] = addr_q[k-1];
            end
            // Stalled or flushed issue enters as a bubble so older producers keep draining
            vld_d[0]  = bus.issue_valid && bus.issue_wr_en && bus.issue_wr_addr != '0 &&
                        !stall_int && !bus.flush;
            ld_d[0]   = bus.issue_is_load;
            addr_d[0] = bus.issue_wr_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vld_q <= '0;
        else          vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
        ld_q   <= ld_d;
        addr_q <= addr_d;
    end

    assign bus.fwd_sel_a  = sel_a;
    assign bus.fwd_sel_b  = sel_b;
    assign bus.stall      = stall_int;
    assign bus.table_busy = |vld_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (bus.cnt_clr) begin
            stall_cnt_d = '0;
            fwd_cnt_d   = '0;
        end else begin
            if (stall_int && !bus.hold && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_d = stall_cnt_q + 32'd1;
            if (!bus.hold && bus.issue_valid && !bus.flush && !stall_int &&
                (sel_a != '0 || sel_b != '0) && fwd_cnt_q != 32'hFFFF_FFFF)
                fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit (DEPTH=2, LOAD_AVAIL=1): stimulus pushes expectations,
// a negedge monitor pops and compares.
module tb_hazard_fwd_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hazard_fwd_unit_if #(.REG_AW(5), .SEL_W(3)) bus ();

    hazard_fwd_unit #(.REG_AW(5), .DEPTH(2), .LOAD_AVAIL(1), .SEL_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string      nm;
        logic [2:0] a;
        logic [2:0] b;
        logic       st;
        logic       busy;
        logic       chk_cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: one expectation per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if (bus.fwd_sel_a !== e.a || bus.fwd_sel_b !== e.b ||
                bus.stall !== e.st || bus.table_busy !== e.busy) begin
                n_bad++;
                $display("FAIL %s: got a=%0d b=%0d stall=%0b busy=%0b, want a=%0d b=%0d stall=%0b busy=%0b",
                         e.nm, bus.fwd_sel_a, bus.fwd_sel_b, bus.stall, bus.table_busy,
                         e.a, e.b, e.st, e.busy);
            end
`ifdef HAZ_PERF_CNT_EN
            if (e.chk_cnt) begin
                n_cmp++;
                if (bus.stall_cnt !== 32'd0 || bus.fwd_cnt !== 32'd0) begin
                    n_bad++;
                    $display("FAIL %s_cnt: got stall_cnt=%0d fwd_cnt=%0d, want 0 0",
                             e.nm, bus.stall_cnt, bus.fwd_cnt);
                end
            end
`endif
        end
    end

    task automatic step(input string nm, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic wen, input logic [4:0] wa,
                        input logic ld, input logic fl, input logic hd,
                        input logic [2:0] ea, input logic [2:0] eb, input logic es, input logic ebusy);
        exp_t e;
        @(posedge clk);
        #1;
        bus.issue_valid   = v;
        bus.issue_rs      = rs;
        bus.issue_rt      = rt;
        bus.issue_use_rs  = urs;
        bus.issue_use_rt  = urt;
        bus.issue_wr_en   = wen;
        bus.issue_wr_addr = wa;
        bus.issue_is_load = ld;
        bus.flush         = fl;
        bus.hold          = hd;
        e.nm = nm; e.a = ea; e.b = eb; e.st = es; e.busy = ebusy; e.chk_cnt = 1'b0;
        sb.push_back(e);
    endtask

    task automatic idle(input string nm, input logic ebusy);
        step(nm, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, ebusy);
    endtask

    initial begin
        exp_t e;
        int   guard;
        bus.hold = 1'b0; bus.flush = 1'b0; bus.issue_valid = 1'b0;
        bus.issue_rs = '0; bus.issue_rt = '0; bus.issue_use_rs = 1'b0; bus.issue_use_rt = 1'b0;
        bus.issue_wr_en = 1'b0; bus.issue_wr_addr = '0; bus.issue_is_load = 1'b0;
`ifdef HAZ_PERF_CNT_EN
        bus.cnt_clr = 1'b0;
`endif
        idle("reset_state", 1'b0);
        @(posedge clk); #2 reset_n = 1'b1;

        // ALU-to-ALU forwarding, distance 1 and 2
        step("addu_r3",      1, 5'd1, 5'd2, 1, 1, 1, 5'd3,  0, 0, 0, 3'd0, 3'd0, 0, 0);
        step("fwd_dist1",    1, 5'd3, 5'd5, 1, 1, 1, 5'd4,  0, 0, 0, 3'd1, 3'd0, 0, 1);
        step("unrelated",    1, 5'd6, 5'd7, 1, 1, 1, 5'd10, 0, 0, 0, 3'd0, 3'd0, 0, 1);
        step("fwd_dist2",    1, 5'd4, 5'd9, 1, 1, 1, 5'd11, 0, 0, 0, 3'd2, 3'd0, 0, 1);
        // r0 is never a producer
        step("wr_r0",        1, 5'd1, 5'd1, 1, 1, 1, 5'd0,  0, 0, 0, 3'd0, 3'd0, 0, 1);
        step("rd_r0",        1, 5'd0, 5'd0, 1, 1, 1, 5'd12, 0, 0, 0, 3'd0, 3'd0, 0, 1);
        idle("drain1", 1'b1);
        idle("drain2", 1'b1);
        idle("empty",  1'b0);
        // Load-use: one stall cycle, then forward from stage 1
        step("lw_r8",        1, 5'd1, 5'd0, 1, 0, 1, 5'd8,  1, 0, 0, 3'd0, 3'd0, 0, 0);
        step("ldu_stall",    1, 5'd8, 5'd8, 1, 1, 1, 5'd9,  0, 0, 0, 3'd1, 3'd1, 1, 1);
        step("ldu_fwd",      1, 5'd8, 5'd8, 1, 1, 1, 5'd9,  0, 0, 0, 3'd2, 3'd2, 0, 1);
        idle("drain3", 1'b1);
        idle("drain4", 1'b1);
        // Younger load beats older ALU producer of the same register
        step("addu_r5",      1, 5'd1, 5'd2, 1, 1, 1, 5'd5,  0, 0, 0, 3'd0, 3'd0, 0, 0);
        step("lw_r5",        1, 5'd1, 5'd2, 1, 1, 1, 5'd5,  1, 0, 0, 3'd0, 3'd0, 0, 1);
        step("ld_wins",      1, 5'd5, 5'd5, 1, 1, 1, 5'd6,  0, 0, 0, 3'd1, 3'd1, 1, 1);
        step("ld_wins_fwd",  1, 5'd5, 5'd5, 1, 1, 1, 5'd6,  0, 0, 0, 3'd2, 3'd2, 0, 1);
        // Same with flush on the reader: no stall, reader becomes a bubble
        step("addu_r5b",     1, 5'd1, 5'd2, 1, 1, 1, 5'd5,  0, 0, 0, 3'd0, 3'd0, 0, 1);
        step("lw_r5b",       1, 5'd1, 5'd2, 1, 1, 1, 5'd5,  1, 0, 0, 3'd0, 3'd0, 0, 1);
        step("flush_nostall",1, 5'd5, 5'd5, 1, 1, 1, 5'd7,  0, 1, 0, 3'd1, 3'd1, 0, 1);
        step("flush_bubble", 1, 5'd7, 5'd5, 1, 1, 0, 5'd0,  0, 0, 0, 3'd0, 3'd2, 0, 1);
        idle("empty2", 1'b0);
        // Load-use under hold: frozen for 3 cycles, then normal one-cycle stall
        step("lw_r8b",       1, 5'd1, 5'd0, 1, 0, 1, 5'd8,  1, 0, 0, 3'd0, 3'd0, 0, 0);
        step("hold1",        1, 5'd8, 5'd8, 1, 1, 1, 5'd9,  0, 0, 1, 3'd1, 3'd1, 1, 1);
        step("hold2",        1, 5'd8, 5'd8, 1, 1, 1, 5'd9,  0, 0, 1, 3'd1, 3'd1, 1, 1);
        step("hold3",        1, 5'd8, 5'd8, 1, 1, 1, 5'd9,  0, 0, 1, 3'd1, 3'd1, 1, 1);
        step("hold_release", 1, 5'd8, 5'd8, 1, 1, 1, 5'd9,  0, 0, 0, 3'd1, 3'd1, 1, 1);
        step("hold_fwd",     1, 5'd8, 5'd8, 1, 1, 1, 5'd9,  0, 0, 0, 3'd2, 3'd2, 0, 1);
        // Flush together with hold: table must not move
        step("flush_hold",   1, 5'd9, 5'd0, 1, 0, 1, 5'd10, 0, 1, 1, 3'd1, 3'd0, 0, 1);
        step("after_fh",     1, 5'd9, 5'd0, 1, 0, 0, 5'd0,  0, 0, 0, 3'd1, 3'd0, 0, 1);
        // Fill the table, stall under hold, then reset asynchronously
        step("addu_r2",      1, 5'd1, 5'd0, 1, 0, 1, 5'd2,  0, 0, 0, 3'd0, 3'd0, 0, 1);
        step("lw_r8c",       1, 5'd1, 5'd0, 1, 0, 1, 5'd8,  1, 0, 0, 3'd0, 3'd0, 0, 1);
        step("full_stall",   1, 5'd8, 5'd8, 1, 1, 1, 5'd9,  0, 0, 1, 3'd1, 3'd1, 1, 1);
        step("full_stall2",  1, 5'd8, 5'd8, 1, 1, 1, 5'd9,  0, 0, 1, 3'd1, 3'd1, 1, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        e.nm = "async_reset"; e.a = 3'd0; e.b = 3'd0; e.st = 1'b0; e.busy = 1'b0; e.chk_cnt = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        #1 reset_n = 1'b1;
        step("post_reset",   1, 5'd8, 5'd8, 1, 1, 0, 5'd0,  0, 0, 0, 3'd0, 3'd0, 0, 0);
        idle("post_reset2", 1'b0);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised successor to the CPU's hard-wired one-deep forwarding select.
- Tracks DEPTH in-flight writeback producers in a shift table and drives per-operand forward selects for the issuing instruction.
- Asserts a load-use stall when load data is not yet forwardable; handles flush, bubbles and whole-pipeline hold.
- Sits between decode and the ALU operand muxes of the execute stage.

Parameters:
- REG_AW, 5: register address width; register 0 is hardwired zero.
- DEPTH, 2: number of tracked producer stages (range 1..7).
- LOAD_AVAIL, 1: lowest stage index from which load data may be forwarded (0..DEPTH).
- SEL_W, 3: width of each forward select; must satisfy 2^SEL_W > DEPTH.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- hold  in  1  global freeze (cache/UART wait); table holds
- flush  in  1  kill the issuing instruction (taken branch/jump)
- issue_valid  in  1  issuing slot holds a real instruction
- issue_rs  in  REG_AW  source A register
- issue_rt  in  REG_AW  source B register
- issue_use_rs  in  1  instruction reads rs
- issue_use_rt  in  1  instruction reads rt
- issue_wr_en  in  1  instruction writes a register
- issue_wr_addr  in  REG_AW  destination (rd/rt/r31 already resolved)
- issue_is_load  in  1  destination value comes from memory
- fwd_sel_a  out  SEL_W  0 = register file, k+1 = forward from stage k
- fwd_sel_b  out  SEL_W  as fwd_sel_a, for rt
- stall  out  1  load-use stall; decode/PC must hold
- table_busy  out  1  any stage entry valid

Behaviour:
- Table: entries stage[0..DEPTH-1], each {valid, addr, is_load}. Stage 0 is one cycle older than issue.
- Reset (async, reset_n low): all entries invalid. fwd_sel_a = fwd_sel_b = 0, stall = 0, table_busy = 0 while table is empty.
- Match rule: stage k matches operand X when valid && addr == X && addr != 0 && issue_use_X && issue_valid. The lowest matching k (youngest) wins.
- fwd_sel_X = k+1 on a match, else 0. Combinational from table and issue inputs; zero latency.
- Load-use: the winning match for either operand has is_load and k < LOAD_AVAIL, so stall = 1.
  - During a stall, fwd_sel for that operand is still driven but is don't-care.
  - An older non-load match never overrides a younger load match.
- Advance on each rising edge with hold = 0:
  - stage[k+1] <= stage[k]; stage[DEPTH-1] drops out.
  - stage[0] <= {issue_valid && issue_wr_en && issue_wr_addr != 0 && !stall && !flush, issue_wr_addr, issue_is_load}.
  - A stall inserts a bubble in stage 0 while older entries continue to drain, so the stall self-clears after (LOAD_AVAIL - k) cycles.
- hold = 1: table unchanged, selects/stall still evaluated combinationally. hold overrides stall and flush for table update; the bubble is not inserted.
- flush = 1: forces stall = 0; the issuing instruction enters stage 0 as a bubble. Older entries are not affected.
- Simultaneous flush and hold: table holds; stall = 0.
- LOAD_AVAIL = 0: stall is never asserted.
- DEPTH = 1: single-entry behaviour, equivalent to the legacy one-deep forwarding.
- table_busy = OR of all valid bits (registered state only).
- Deasserting reset_n mid-stall clears the table; stall drops asynchronously with it.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs stall_cnt [31:0] and fwd_cnt [31:0], plus input cnt_clr.
  - stall_cnt increments on each edge with stall && !hold.
  - fwd_cnt increments on each edge with hold = 0, issue_valid, !flush, !stall and any nonzero select.
  - Both saturate at 32'hFFFFFFFF, reset to 0 on reset_n low or cnt_clr = 1. cnt_clr has priority over increment.
- Undefined: no counters, no extra ports; logic is identical otherwise.

Test Plan:
- addu r3 then addu r4,r3,r5 back-to-back (DEPTH=2) -> fwd_sel_a = 1, fwd_sel_b = 0, stall = 0. With one unrelated instruction between them -> fwd_sel_a = 2.
- lw r8 then addu r9,r8,r8 (LOAD_AVAIL=1) -> stall = 1 for exactly 1 cycle, bubble in stage 0. Next cycle fwd_sel_a = fwd_sel_b = 2, stall = 0.
- Write to r0 followed by reader of r0 -> fwd_sel = 0, no stall.
- addu r5 (older), lw r5 (younger), then reader of r5 -> load match wins, stall = 1. Same sequence with flush = 1 on the reader -> stall = 0, stage 0 receives a bubble.
- Load-use stall with hold = 1 held for 3 cycles -> table frozen, stall stays 1. Release hold -> bubble inserted, stall clears next cycle.
- reset_n pulsed low while the table is full and stall = 1 -> stall, selects and table_busy drop to 0 immediately without a clock edge. With HAZ_PERF_CNT_EN, counters read 0.
